// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state encoding for the serial pattern detector
//
// Purpose: state type and encoding shared by seq_det_ctrl and anything that
// decodes its state output (display logic, benches).
// Ports: none (package).

package seq_det_pkg;

    localparam int STATE_W = 2;

    // ILLEGAL is never entered on purpose; it exists so the decoder has a
    // name for the fourth code and can steer it back to IDLE.
    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        RUN     = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

endpackage : seq_det_pkg

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing a one-cycle sample strobe every DIV clocks
//
// Purpose: replaces the old divided clock. While EN is high a counter walks
// 0..DIV-1 and wraps; the strobe is a registered image of the terminal count,
// so the first strobe is high in the cycle that starts DIV edges after the
// first edge that sees EN=1, and one strobe follows every DIV cycles after.
// Ports:
//   CLK  - system clock, rising edge
//   RST  - asynchronous active-high reset
//   EN   - run enable; low holds the counter at 0 and suppresses the strobe
//   tick - one-cycle sample strobe (registered)

module tick_gen #(
    parameter int DIV = 5
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TOP = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (EN) begin
            tick_d = (cnt_q == TOP);
            cnt_d  = (cnt_q == TOP) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule : tick_gen

// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - single-clock controller for the overlapping serial pattern matcher
//
// Purpose: arms on EN, fills a shift register with PAT_W bits of code taken
// on sample ticks, then compares every new window against PATTERN, pulsing
// detected and bumping a saturating match counter.
// Ports:
//   CLK       - system clock, rising edge
//   RST       - asynchronous active-high reset
//   EN        - run enable (level); low returns to IDLE and drops history
//   clr       - synchronous clear of det_count, wins over an increment
//   code      - serial data bit, used only on tick cycles
//   tick      - one-cycle sample strobe from the prescaler
//   detected  - one-cycle match pulse, one cycle after the sampling edge
//   det_count - saturating match count
//   state     - current FSM state (IDLE=0, FILL=1, RUN=2)

module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int                PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PATTERN = 4'b1011,
    parameter int                DIV     = 5,
    parameter int                CNT_W   = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               clr,
    input  logic               code,
    output logic               tick,
    output logic               detected,
    output logic [CNT_W-1:0]   det_count,
    output logic [1:0]         state
);

    localparam int FW = $clog2(PAT_W);
    localparam logic [FW-1:0] FILL_LAST = FW'(PAT_W - 1);

    logic tick_w;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .tick (tick_w)
    );

    state_t             state_q, state_d;
    // Only the newest PAT_W-1 bits are kept: the oldest bit of a window is
    // shifted out on the very edge it is compared, so it never needs storage.
    logic [PAT_W-2:0]   sreg_q, sreg_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               det_q, det_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [PAT_W-1:0]   window;
    logic               hit;

    assign window = {sreg_q, code};
    assign hit    = (window == PATTERN);

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        fill_d  = fill_q;
        det_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (EN) begin
                    state_d = FILL;
                    sreg_d  = '0;
                    fill_d  = '0;
                end
            end
            FILL: begin
                if (!EN) begin
                    state_d = IDLE;
                    sreg_d  = '0;
                    fill_d  = '0;
                end else if (tick_w) begin
                    sreg_d = window[PAT_W-2:0];
                    fill_d = fill_q + 1'b1;
                    // The bit that completes the window is compared right away,
                    // so a match is possible on the PAT_W-th sample.
                    if (fill_q == FILL_LAST) begin
                        state_d = RUN;
                        det_d   = hit;
                    end
                end
            end
            RUN: begin
                if (!EN) begin
                    state_d = IDLE;
                    sreg_d  = '0;
                    fill_d  = '0;
                end else if (tick_w) begin
                    sreg_d = window[PAT_W-2:0];
                    det_d  = hit;
                end
            end
            default: begin
                state_d = IDLE;
                sreg_d  = '0;
                fill_d  = '0;
            end
        endcase

        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (det_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            fill_q  <= '0;
            det_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            fill_q  <= fill_d;
            det_q   <= det_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tick      = tick_w;
    assign detected  = det_q;
    assign det_count = cnt_q;
    assign state     = state_q;

endmodule : seq_det_ctrl

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - self-checking bench for seq_det_ctrl

module tb_seq_det_ctrl;
    import seq_det_pkg::*;

    localparam int DIV = 5;

    logic CLK = 1'b0;
    logic RST, EN, clr, code;

    always #5 CLK = ~CLK;

    logic       tick0, tick1, tick2;
    logic       det0, det1, det2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    logic [1:0] st0, st1, st2;

    // 0: defaults, 1: all-zero pattern, 2: 2-bit counter
    seq_det_ctrl #(.PAT_W(4), .PATTERN(4'b1011), .DIV(DIV), .CNT_W(8)) dut0 (
        .CLK(CLK), .RST(RST), .EN(EN), .clr(clr), .code(code),
        .tick(tick0), .detected(det0), .det_count(cnt0), .state(st0));
    seq_det_ctrl #(.PAT_W(4), .PATTERN(4'b0000), .DIV(DIV), .CNT_W(8)) dut1 (
        .CLK(CLK), .RST(RST), .EN(EN), .clr(clr), .code(code),
        .tick(tick1), .detected(det1), .det_count(cnt1), .state(st1));
    seq_det_ctrl #(.PAT_W(4), .PATTERN(4'b1011), .DIV(DIV), .CNT_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .EN(EN), .clr(clr), .code(code),
        .tick(tick2), .detected(det2), .det_count(cnt2), .state(st2));

    int checks = 0;
    int failures = 0;

    // Reference model: sample history since the last enable, edge count
    // since EN went high, and per-instance expected pulse/count.
    int         k;
    logic       m_tick;
    logic [1:0] m_state;
    bit         hist[$];
    logic       m_det[3];
    int         m_cnt[3];
    logic [3:0] m_pat[3];
    int         m_max[3];

    function automatic logic obs_det(int i);
        return (i == 0) ? det0 : (i == 1) ? det1 : det2;
    endfunction
    function automatic logic obs_tick(int i);
        return (i == 0) ? tick0 : (i == 1) ? tick1 : tick2;
    endfunction
    function automatic int obs_cnt(int i);
        return (i == 0) ? int'(cnt0) : (i == 1) ? int'(cnt1) : int'(cnt2);
    endfunction
    function automatic logic [1:0] obs_state(int i);
        return (i == 0) ? st0 : (i == 1) ? st1 : st2;
    endfunction

    task automatic model_reset();
        k = 0;
        m_tick = 1'b0;
        m_state = IDLE;
        hist.delete();
        for (int i = 0; i < 3; i++) begin
            m_det[i] = 1'b0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic model_edge();
        logic       prev;
        logic [3:0] win;
        prev = m_tick;
        for (int i = 0; i < 3; i++) m_det[i] = 1'b0;
        if (!EN) begin
            k = 0;
            m_tick = 1'b0;
            m_state = IDLE;
            hist.delete();
        end else begin
            k++;
            m_tick = ((k % DIV) == 0);
            if (m_state == IDLE) begin
                m_state = FILL;
                hist.delete();
            end else if (prev) begin
                hist.push_back(code);
                if (hist.size() > 4) void'(hist.pop_front());
                if (hist.size() == 4) begin
                    m_state = RUN;
                    win = {hist[0], hist[1], hist[2], hist[3]};
                    for (int i = 0; i < 3; i++) m_det[i] = (win == m_pat[i]);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (clr) m_cnt[i] = 0;
            else if (m_det[i] && m_cnt[i] < m_max[i]) m_cnt[i]++;
        end
    endtask

    task automatic step(input logic e, input logic c, input logic d);
        EN = e;
        clr = c;
        code = d;
        @(posedge CLK);
        if (!RST) model_edge();
        #1;
    endtask

    // Runs filler cycles (random code) until the next edge samples, then
    // presents bit b on that sampling edge.
    task automatic sample_bit(input logic b, input logic c);
        int guard;
        guard = 0;
        while (!m_tick && guard < 4 * DIV) begin
            step(1'b1, 1'b0, 1'($urandom));
            guard++;
        end
        step(1'b1, c, b);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 1'b0);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        model_reset();
        repeat (2) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_tick(i) !== 1'b0 || obs_det(i) !== 1'b0 || obs_cnt(i) !== 0 || obs_state(i) !== IDLE) begin
                failures++;
                $display("FAIL reset[%0d] got tick=%0b det=%0b cnt=%0d st=%0d exp 0/0/0/0",
                         i, obs_tick(i), obs_det(i), obs_cnt(i), obs_state(i));
            end
        end
        RST = 1'b0;
    endtask

    task automatic test_overlap();
        logic [6:0] bits;
        logic [6:0] pulses;
        bits   = 7'b1011011;
        pulses = 7'b0001001;
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (st0 !== FILL) begin
            failures++;
            $display("FAIL overlap_fill got=%0d exp=%0d", st0, FILL);
        end
        for (int n = 0; n < 7; n++) begin
            sample_bit(bits[6-n], 1'b0);
            checks++;
            if (det0 !== pulses[6-n] || det0 !== m_det[0] || int'(cnt0) !== m_cnt[0]) begin
                failures++;
                $display("FAIL overlap_bit%0d got det=%0b cnt=%0d exp det=%0b cnt=%0d",
                         n + 1, det0, cnt0, pulses[6-n], m_cnt[0]);
            end
            if (n == 3) begin
                checks++;
                if (st0 !== RUN) begin
                    failures++;
                    $display("FAIL overlap_run got=%0d exp=%0d", st0, RUN);
                end
            end
        end
        checks++;
        if (cnt0 !== 8'd2) begin
            failures++;
            $display("FAIL overlap_count got=%0d exp=2", cnt0);
        end
    endtask

    task automatic test_en_drop();
        logic [3:0] bits;
        sample_bit(1'b1, 1'b0);
        sample_bit(1'b0, 1'b0);
        sample_bit(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'($urandom));
        checks++;
        if (st0 !== IDLE || cnt0 !== 8'd2) begin
            failures++;
            $display("FAIL en_drop_idle got st=%0d cnt=%0d exp st=0 cnt=2", st0, cnt0);
        end
        sample_bit(1'b1, 1'b0);
        checks++;
        if (det0 !== 1'b0) begin
            failures++;
            $display("FAIL en_drop_stale got=%0b exp=0", det0);
        end
        bits = 4'b1011;
        for (int n = 0; n < 4; n++) begin
            sample_bit(bits[3-n], 1'b0);
            checks++;
            if (det0 !== (n == 3) || det0 !== m_det[0]) begin
                failures++;
                $display("FAIL en_drop_bit%0d got=%0b exp=%0b", n, det0, (n == 3));
            end
        end
        checks++;
        if (cnt0 !== 8'd3) begin
            failures++;
            $display("FAIL en_drop_count got=%0d exp=3", cnt0);
        end
    endtask

    task automatic test_fill_guard();
        do_reset();
        for (int t = 1; t <= 8; t++) begin
            sample_bit(1'b0, 1'b0);
            checks++;
            if (det1 !== (t >= 4) || int'(cnt1) !== m_cnt[1]) begin
                failures++;
                $display("FAIL fill_guard_tick%0d got det=%0b cnt=%0d exp det=%0b cnt=%0d",
                         t, det1, cnt1, (t >= 4), m_cnt[1]);
            end
        end
        checks++;
        if (cnt1 !== 8'd5) begin
            failures++;
            $display("FAIL fill_guard_count got=%0d exp=5", cnt1);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] bits;
        int          npulse;
        bits = 16'b1011011011011011;
        npulse = 0;
        do_reset();
        for (int n = 0; n < 16; n++) begin
            sample_bit(bits[15-n], 1'b0);
            if (det2 === 1'b1) npulse++;
            checks++;
            if (det2 !== m_det[2] || int'(cnt2) !== m_cnt[2]) begin
                failures++;
                $display("FAIL sat_bit%0d got det=%0b cnt=%0d exp det=%0b cnt=%0d",
                         n, det2, cnt2, m_det[2], m_cnt[2]);
            end
        end
        checks++;
        if (cnt2 !== 2'd3 || npulse !== 5) begin
            failures++;
            $display("FAIL sat_final got cnt=%0d pulses=%0d exp cnt=3 pulses=5", cnt2, npulse);
        end
    endtask

    task automatic test_clr_collision();
        logic [9:0] bits;
        bits = 10'b1011011011;
        do_reset();
        for (int n = 0; n < 10; n++) sample_bit(bits[9-n], (n == 9));
        checks++;
        if (det0 !== 1'b1 || cnt0 !== 8'd0) begin
            failures++;
            $display("FAIL clr_collision got det=%0b cnt=%0d exp det=1 cnt=0", det0, cnt0);
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] bits;
        bits = 7'b1011011;
        do_reset();
        for (int n = 0; n < 7; n++) sample_bit(bits[6-n], 1'b0);
        step(1'b1, 1'b0, 1'b0);
        #3;
        RST = 1'b1;
        #1;
        checks++;
        if (st0 !== IDLE || cnt0 !== 8'd0 || det0 !== 1'b0 || tick0 !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got st=%0d cnt=%0d det=%0b tick=%0b exp 0/0/0/0",
                     st0, cnt0, det0, tick0);
        end
        model_reset();
        #1;
        RST = 1'b0;
        for (int e = 1; e <= DIV; e++) begin
            step(1'b1, 1'b0, 1'($urandom));
            checks++;
            if (tick0 !== (e == DIV) || st0 !== FILL) begin
                failures++;
                $display("FAIL async_restart_edge%0d got tick=%0b st=%0d exp tick=%0b st=1",
                         e, tick0, st0, (e == DIV));
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 49) != 0, $urandom_range(0, 29) == 0, 1'($urandom));
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_det(i) !== m_det[i] || obs_cnt(i) !== m_cnt[i] ||
                    obs_tick(i) !== m_tick || obs_state(i) !== m_state) begin
                    failures++;
                    $display("FAIL random[%0d] cyc=%0d got det=%0b cnt=%0d tick=%0b st=%0d exp det=%0b cnt=%0d tick=%0b st=%0d",
                             i, n, obs_det(i), obs_cnt(i), obs_tick(i), obs_state(i),
                             m_det[i], m_cnt[i], m_tick, m_state);
                end
            end
        end
    endtask

    initial begin
        m_pat[0] = 4'b1011; m_max[0] = 255;
        m_pat[1] = 4'b0000; m_max[1] = 255;
        m_pat[2] = 4'b1011; m_max[2] = 3;
        RST = 1'b1;
        EN = 1'b0;
        clr = 1'b0;
        code = 1'b0;
        test_reset();
        test_overlap();
        test_en_drop();
        test_fill_guard();
        test_saturation();
        test_clr_collision();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_det_ctrl

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Controller for the serial pattern-detector datapath on the FPGA lab board. It replaces the divided-clock scheme with a single-clock design: an internal prescaler produces a one-cycle sample enable, and an enable-driven state machine arms, fills and runs an overlapping serial pattern matcher on `code`. It also counts matches for display. It sits between the board switches/input pin and the LED/segment display logic, all on `CLK`.

## Interface
- `PAT_W`, default 4: pattern length in bits, legal range 2..16.
- `PATTERN`, default 4'b1011: target sequence, MSB is the oldest bit.
- `DIV`, default 5: `CLK` cycles per sample tick, legal range ≥2.
- `CNT_W`, default 8: width of the match counter.
- `CLK` input, 1 bit: single system clock, rising edge.
- `RST` input, 1 bit: asynchronous, active-high reset.
- `EN` input, 1 bit: run enable (board switch), level-sensitive.
- `clr` input, 1 bit: synchronous clear of the match counter.
- `code` input, 1 bit: serial data bit, sampled only on tick cycles.
- `tick` output, 1 bit: one-cycle sample strobe.
- `detected` output, 1 bit: one-cycle match pulse.
- `det_count` output, `CNT_W` bits: saturating number of matches.
- `state` output, 2 bits: current FSM state.

## Operation
- **Reset values:** `tick`=0, `detected`=0, `det_count`=0, `state`=IDLE. The shift register, fill counter and prescaler are all 0.
- **Prescaler:** counts 0..DIV-1 while `EN`=1 and wraps to 0 at the top.
  - `tick`=1 exactly when the count equals DIV-1, so one pulse every DIV cycles.
  - When `EN`=0 the prescaler is held at 0 and `tick`=0.
- **States:** IDLE=0, FILL=1, RUN=2. Encoding 3 is illegal and recovers to IDLE on the next edge.
- **IDLE:**
  - `EN`=1 moves to FILL on the next edge. The shift register and fill counter are cleared on entry.
- **FILL:**
  - On each tick: shift register ← {sreg[PAT_W-2:0], `code`}, and the fill counter increments.
  - When the fill counter reaches PAT_W-1 and a tick occurs, the FSM goes to RUN. That tick's shift and compare take effect as in RUN, so the first match is possible on the PAT_W-th sampled bit.
  - No match is reported before PAT_W bits have been sampled.
- **RUN:**
  - On each tick, shift as in FILL and compare the new value {sreg[PAT_W-2:0], `code`} against `PATTERN`.
  - On equality, `detected` pulses on the next cycle and `det_count` increments.
  - Matching overlaps: the shift register is not cleared after a match.
- **`EN` deasserted (any state):** go to IDLE on the next edge, clearing the shift register and fill counter. `det_count` is retained.
- **Counter:** saturates at 2^CNT_W−1 with no wrap; `detected` still pulses at saturation.
- **`clr`:** sets `det_count` to 0 on the next edge in any state. If `clr` and an increment coincide, `clr` wins (result 0), but `detected` still pulses.
- **`RST` mid-operation:** all outputs return to their reset values immediately, asynchronously. Operation restarts from IDLE after release.

## Timing
- `tick` is registered. A sample is taken on the same edge where `tick`=1 is seen high.
- Latency from the sampling edge of the completing bit to `detected`=1 is 1 cycle. `det_count` updates on the same edge that `detected` rises.
- `EN` rise: first tick occurs DIV cycles after the edge that registers `EN`=1. `state` shows FILL one cycle after `EN` is registered.
- `EN` fall: a tick in the same cycle as `EN`=0 is ignored.
- `code` must be stable around the tick edge; it is not resynchronized inside this block.

## Structure
- Shared package `seq_det_pkg`: state encoding constants (IDLE, FILL, RUN) and the 2-bit state type.
- One sub-module, `tick_gen` (parameter DIV; ports `CLK`, `RST`, `EN`, `tick`): contains the prescaler.
- The FSM, shift register, comparator and counter live in `seq_det_ctrl`.

## Test plan
All scenarios use defaults PAT_W=4, PATTERN=1011, DIV=5 unless noted.
- **Overlap:** `EN`=1, stream 1,0,1,1,0,1,1 on successive ticks → `detected` pulses after bit 4 and bit 7, `det_count`=2, `state` sequence IDLE→FILL→RUN.
- **Fill guard:** `PATTERN`=4'b0000 with `code` held at 0 from `EN` rise → no pulse on ticks 1–3, first pulse after tick 4, then one pulse every tick; count 5 after 8 ticks.
- **Saturation:** CNT_W=2 with `PATTERN`=1011 and stream 1011011011011011 (5 overlapping matches) → `det_count` stops at 3, `detected` still pulses 5 times.
- **`clr` collision:** assert `clr` in the cycle where `det_count` would go 2→3 → `det_count`=0 and `detected`=1 that cycle.
- **`EN` drop:** drop `EN` after bits 1,0,1, re-enable, then feed 1 → no match; the next full 1,0,1,1 matches. `det_count` is retained across the drop.
- **Async reset:** assert `RST` between clock edges during RUN with `det_count`=2 → outputs go to 0/IDLE before the next edge; after release with `EN`=1, the first tick comes DIV cycles later.
